keypad_encoder: RTL and testbench
=================================

KEYPAD_ENCODER -- requirements
Module: keypad_encoder

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4: consecutive identical samples required to accept a press or a release (legal range 1..15).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port keypad  input  10  raw key lines; bit k high means digit key k is pressed; bouncy and asynchronous to clk.
REQ-005 SHALL have port d  output  4  BCD code of the accepted key.
REQ-006 SHALL have port loadn  output  1  active-low load strobe; its rising edge marks the end of a key event for downstream debounce/decode logic.
REQ-007 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-008 SHALL pass keypad through a two-flop synchronizer before any use; the stated latencies count from the first synchronized sample.
REQ-009 SHALL reduce the synchronized keypad to a 4-bit code: 0..9 for a single key, KEY_NONE (4'hF) for no key.
REQ-010 SHALL implement the FSM IDLE -> SETTLE -> PRESSED -> RELEASE -> IDLE.
REQ-011 IDLE: on code != KEY_NONE, SHALL latch the code into a candidate register, clear the counter to 1, and go to SETTLE.
REQ-012 SETTLE: on code == candidate, SHALL increment the counter; on reaching STABLE_CYCLES, SHALL set d = candidate, drive loadn low, and go to PRESSED in the same edge.
REQ-013 SETTLE: on any code != candidate, including KEY_NONE, SHALL return to IDLE with loadn high and d unchanged.
REQ-014 PRESSED: SHALL hold loadn low and d stable while code == candidate; on code == KEY_NONE, SHALL clear the counter to 1 and go to RELEASE.
REQ-015 PRESSED: a different non-NONE code (key rollover) SHALL be ignored, keeping loadn low and d unchanged.
REQ-016 RELEASE: on code == KEY_NONE, SHALL increment the counter; on reaching STABLE_CYCLES, SHALL drive loadn high and go to IDLE.
REQ-017 RELEASE: any non-NONE code SHALL return to PRESSED without toggling loadn, so release bounce never yields a second loadn edge.
REQ-018 With STABLE_CYCLES=1, press latency SHALL be exactly one sample, with no SETTLE dwell beyond one edge.
REQ-019 Counter width SHALL be 4 bits; the counter SHALL saturate and never wrap.
REQ-020 d SHALL retain the last accepted code after loadn rises, until the next accepted press.

Reset
REQ-021 Asserting resetn low SHALL immediately force state=IDLE, loadn=1, d=4'h0, busy=0, counter=0, candidate=KEY_NONE, and clear both synchronizer stages.
REQ-022 Reset asserted mid-press SHALL produce no loadn edge other than the forced high level; after release of reset, a still-held key SHALL require a full STABLE_CYCLES settle.

Configuration
REQ-023 Macro KEYPAD_MULTIKEY_REJECT_EN defined: two or more keypad bits set SHALL map to KEY_NONE.
REQ-024 Macro KEYPAD_MULTIKEY_REJECT_EN undefined: multiple bits set SHALL resolve by priority, with the highest index winning.

Structure
REQ-025 Package microwave_pkg SHALL hold KEY_NONE, the code width (4), the key count (10), and the FSM state enum.
REQ-026 Key-to-code reduction SHALL be a combinational sub-module keypad_prienc, which carries the macro-dependent logic.

Verification (STABLE_CYCLES=4)
REQ-027 Clean press: keypad=bit7 held 20 cycles, then 0 -> d=7 and loadn falls on the 4th synchronized sample; loadn rises on the 4th zero sample.
REQ-028 Bounce: keypad toggles bit3 on/off every cycle for 6 cycles, then holds bit3 -> loadn falls only on the 4th stable sample; d=3; exactly one falling edge.
REQ-029 Release bounce: while PRESSED with d=5, keypad 0,0,bit5,0,0,0,0 -> loadn stays low until the 4th consecutive zero sample, then a single rising edge.
REQ-030 Multikey: keypad=bits2|8 held 10 cycles -> with macro, loadn stays high and busy=0; without macro, d=8 and loadn falls.
REQ-031 Async reset: resetn low during PRESSED (d=9) -> loadn=1 and d=0 without a clock; key still held after reset -> loadn falls again 4 samples later.

Source files
------------

// File: rtl/microwave_pkg.sv
// Shared keypad definitions: code width, key count, the "no key" code and FSM states.
package microwave_pkg;
    localparam int CODE_W    = 4;
    localparam int KEY_COUNT = 10;
    localparam logic [CODE_W-1:0] KEY_NONE = 4'hF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        PRESSED = 2'd2,
        RELEASE = 2'd3
    } state_t;
endpackage

// File: rtl/keypad_prienc.sv
// Reduces the key lines to a BCD code, or KEY_NONE when no key is pressed.
// KEYPAD_MULTIKEY_REJECT_EN: when defined, two or more pressed keys read as KEY_NONE;
// otherwise the highest pressed index wins.
module keypad_prienc
    import microwave_pkg::*;
(
    input  logic [KEY_COUNT-1:0] i_keys,
    output logic [CODE_W-1:0]    o_code
);

    always_comb begin
        o_code = KEY_NONE;
        for (int k = 0; k < KEY_COUNT; k++) begin
            if (i_keys[k]) begin
                o_code = CODE_W'(k);
            end
        end
`ifdef KEYPAD_MULTIKEY_REJECT_EN
        if ($countones(i_keys) > 1) begin
            o_code = KEY_NONE;
        end
`else
        o_code = o_code;
`endif
    end

endmodule

// File: rtl/keypad_encoder.sv
// Debounced keypad encoder: synchronizes raw keys, accepts a press or release after
// STABLE_CYCLES identical samples, and drives a BCD code with an active-low load strobe.
// Optional multi-key rejection via KEYPAD_MULTIKEY_REJECT_EN (see keypad_prienc).
module keypad_encoder
    import microwave_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
)
(
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [KEY_COUNT-1:0] keypad,
    output logic [CODE_W-1:0]    d,
    output logic                 loadn,
    output logic                 busy
);

    localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);

    logic [KEY_COUNT-1:0] r_sync1;
    logic [KEY_COUNT-1:0] r_sync2;
    logic [CODE_W-1:0]    w_code;
    logic [CODE_W-1:0]    r_cand;
    logic [CODE_W-1:0]    r_d;
    logic [3:0]           r_count;
    logic [3:0]           w_countInc;
    logic                 r_loadn;
    logic                 r_busy;
    state_t               r_state;

    keypad_prienc u_prienc (
        .i_keys (r_sync2),
        .o_code (w_code)
    );

    // Saturating increment so a long dwell can never wrap back below the threshold.
    assign w_countInc = (r_count == 4'hF) ? r_count : r_count + 4'd1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_state <= IDLE;
            r_cand  <= KEY_NONE;
            r_count <= 4'd0;
            r_d     <= 4'h0;
            r_loadn <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_sync1 <= keypad;
            r_sync2 <= r_sync1;
            case (r_state)
                IDLE: begin
                    if (w_code != KEY_NONE) begin
                        r_cand  <= w_code;
                        r_count <= 4'd1;
                        r_busy  <= 1'b1;
                        // A threshold of one accepts the very first sample.
                        if (STABLE <= 4'd1) begin
                            r_d     <= w_code;
                            r_loadn <= 1'b0;
                            r_state <= PRESSED;
                        end else begin
                            r_state <= SETTLE;
                        end
                    end
                end
                SETTLE: begin
                    if (w_code == r_cand) begin
                        r_count <= w_countInc;
                        if (w_countInc >= STABLE) begin
                            r_d     <= r_cand;
                            r_loadn <= 1'b0;
                            r_state <= PRESSED;
                        end
                    end else begin
                        r_loadn <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                PRESSED: begin
                    if (w_code == KEY_NONE) begin
                        r_count <= 4'd1;
                        if (STABLE <= 4'd1) begin
                            r_loadn <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end else begin
                            r_state <= RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    if (w_code == KEY_NONE) begin
                        r_count <= w_countInc;
                        if (w_countInc >= STABLE) begin
                            r_loadn <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end
                    end else begin
                        r_state <= PRESSED;
                    end
                end
                default: begin
                    r_loadn <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign d     = r_d;
    assign loadn = r_loadn;
    assign busy  = r_busy;

endmodule

// File: tb/tb_keypad_encoder.sv
// Directed bench for keypad_encoder with STABLE_CYCLES=4; keys are driven 1 time unit after
// each rising edge and outputs are checked 1 time unit after the following edges.
module tb_keypad_encoder;
    import microwave_pkg::*;

    logic       clk;
    logic       resetn;
    logic [9:0] keypad;
    logic [3:0] d;
    logic       loadn;
    logic       busy;

    int vectorCount = 0;
    int failCount   = 0;
    int fallCount   = 0;
    int riseCount   = 0;
    int fallBefore;
    int riseBefore;

    keypad_encoder #(.STABLE_CYCLES(4)) dut (
        .clk    (clk),
        .resetn (resetn),
        .keypad (keypad),
        .d      (d),
        .loadn  (loadn),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge loadn) fallCount++;
    always @(posedge loadn) riseCount++;

    task automatic applyStimulus(input logic [9:0] keys, input int edges);
        keypad = keys;
        repeat (edges) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        vectorCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        resetn = 1'b0;
        keypad = 10'h000;
        #12;
        checkOutput("reset_loadn", {7'd0, loadn}, 8'h01);
        checkOutput("reset_d",     {4'd0, d},     8'h00);
        checkOutput("reset_busy",  {7'd0, busy},  8'h00);
        resetn = 1'b1;
        applyStimulus(10'h000, 2);

        // Clean press of key 7, with a rollover to key 2 while held
        fallBefore = fallCount;
        applyStimulus(10'h080, 2);
        checkOutput("press7_idle_busy", {7'd0, busy}, 8'h00);
        applyStimulus(10'h080, 1);
        checkOutput("press7_settle_busy", {7'd0, busy}, 8'h01);
        applyStimulus(10'h080, 2);
        checkOutput("press7_loadn_pre", {7'd0, loadn}, 8'h01);
        applyStimulus(10'h080, 1);
        checkOutput("press7_loadn_fall", {7'd0, loadn}, 8'h00);
        checkOutput("press7_d", {4'd0, d}, 8'h07);
        applyStimulus(10'h080, 14);
        applyStimulus(10'h004, 3);
        checkOutput("rollover_d", {4'd0, d}, 8'h07);
        checkOutput("rollover_loadn", {7'd0, loadn}, 8'h00);
        applyStimulus(10'h000, 5);
        checkOutput("release7_loadn_pre", {7'd0, loadn}, 8'h00);
        applyStimulus(10'h000, 1);
        checkOutput("release7_loadn_rise", {7'd0, loadn}, 8'h01);
        checkOutput("release7_busy", {7'd0, busy}, 8'h00);
        checkOutput("release7_d_retained", {4'd0, d}, 8'h07);
        checkOutput("press7_falls", 8'(fallCount - fallBefore), 8'h01);
        applyStimulus(10'h000, 2);

        // Press bounce on key 3
        fallBefore = fallCount;
        for (int i = 0; i < 6; i++) begin
            applyStimulus((i % 2 == 0) ? 10'h008 : 10'h000, 1);
        end
        applyStimulus(10'h008, 5);
        checkOutput("bounce3_loadn_pre", {7'd0, loadn}, 8'h01);
        applyStimulus(10'h008, 1);
        checkOutput("bounce3_loadn_fall", {7'd0, loadn}, 8'h00);
        checkOutput("bounce3_d", {4'd0, d}, 8'h03);
        checkOutput("bounce3_falls", 8'(fallCount - fallBefore), 8'h01);
        applyStimulus(10'h000, 6);
        checkOutput("bounce3_release", {7'd0, loadn}, 8'h01);
        applyStimulus(10'h000, 2);

        // Release bounce on key 5
        applyStimulus(10'h020, 6);
        checkOutput("press5_loadn", {7'd0, loadn}, 8'h00);
        checkOutput("press5_d", {4'd0, d}, 8'h05);
        riseBefore = riseCount;
        applyStimulus(10'h000, 1);
        applyStimulus(10'h000, 1);
        applyStimulus(10'h020, 1);
        applyStimulus(10'h000, 5);
        checkOutput("relbounce_loadn_pre", {7'd0, loadn}, 8'h00);
        checkOutput("relbounce_busy_pre", {7'd0, busy}, 8'h01);
        applyStimulus(10'h000, 1);
        checkOutput("relbounce_loadn_rise", {7'd0, loadn}, 8'h01);
        applyStimulus(10'h000, 4);
        checkOutput("relbounce_rises", 8'(riseCount - riseBefore), 8'h01);

        // Two keys held together
        applyStimulus(10'h104, 10);
`ifdef KEYPAD_MULTIKEY_REJECT_EN
        checkOutput("multikey_loadn", {7'd0, loadn}, 8'h01);
        checkOutput("multikey_busy", {7'd0, busy}, 8'h00);
        checkOutput("multikey_d", {4'd0, d}, 8'h05);
`else
        checkOutput("multikey_loadn", {7'd0, loadn}, 8'h00);
        checkOutput("multikey_busy", {7'd0, busy}, 8'h01);
        checkOutput("multikey_d", {4'd0, d}, 8'h08);
`endif
        applyStimulus(10'h000, 8);
        checkOutput("multikey_release", {7'd0, loadn}, 8'h01);

        // Asynchronous reset while key 9 is held
        applyStimulus(10'h200, 6);
        checkOutput("press9_loadn", {7'd0, loadn}, 8'h00);
        checkOutput("press9_d", {4'd0, d}, 8'h09);
        #1;
        resetn = 1'b0;
        #1;
        checkOutput("async_reset_loadn", {7'd0, loadn}, 8'h01);
        checkOutput("async_reset_d", {4'd0, d}, 8'h00);
        checkOutput("async_reset_busy", {7'd0, busy}, 8'h00);
        #1;
        resetn = 1'b1;
        fallBefore = fallCount;
        applyStimulus(10'h200, 5);
        checkOutput("after_reset_loadn_pre", {7'd0, loadn}, 8'h01);
        applyStimulus(10'h200, 1);
        checkOutput("after_reset_loadn_fall", {7'd0, loadn}, 8'h00);
        checkOutput("after_reset_d", {4'd0, d}, 8'h09);
        checkOutput("after_reset_falls", 8'(fallCount - fallBefore), 8'h01);
        applyStimulus(10'h000, 6);
        checkOutput("after_reset_release", {7'd0, loadn}, 8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, failCount);
        $finish;
    end

endmodule
